// File: rtl/phys_pkg.sv
// Shared vertical-physics constants and state encoding for the player and collision stages.
package phys_pkg;

  localparam int unsigned POS_W = 11;
  localparam int unsigned VEL_W = 6;
  localparam int unsigned CMP_W = 12;

  localparam int GROUND_Y   = 400;
  localparam int PLATFORM_Y = 215;
  localparam int SPAWN_Y    = 100;
  localparam int JUMP_VEL   = -12;
  localparam int GRAVITY    = 1;
  localparam int MAX_FALL   = 10;

  typedef enum logic [1:0] {
    ST_GROUND   = 2'd0,
    ST_PLATFORM = 2'd1,
    ST_AIRBORNE = 2'd2
  } phys_state_e;

  // Bottom edge after this frame's move, widened so large positions cannot wrap.
  function automatic logic signed [CMP_W-1:0] bottom_edge(
    input logic signed [POS_W-1:0] y,
    input logic signed [VEL_W-1:0] v,
    input logic signed [CMP_W-1:0] full_h
  );
    return CMP_W'(y) + CMP_W'(v) + full_h;
  endfunction

endpackage

// File: rtl/jump_req_latch.sv
// Rising-edge detector on the jump button feeding a sticky request held until consumed.
module jump_req_latch (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  input  logic consume,
  output logic req
);

  logic btn_prev;

  // An edge arriving in the consuming cycle survives to the following frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      btn_prev <= 1'b0;
      req      <= 1'b0;
    end else begin
      btn_prev <= btn;
      req      <= (btn & ~btn_prev) | (req & ~consume);
    end
  end

endmodule

// File: rtl/player_vert_physics.sv
// Per-frame vertical motion of the player: gravity, multi-jump, floor and platform landing.
module player_vert_physics
  import phys_pkg::*;
#(
  parameter int HEIGHT    = 30,
  parameter int MAX_JUMPS = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    frame_tick,
  input  logic                    jump_btn,
  input  logic                    touching_platform,
  input  logic                    over_platform,
  output logic signed [POS_W-1:0] y_pos,
  output logic signed [POS_W-1:0] next_y,
  output logic signed [VEL_W-1:0] vel_y,
  output logic                    grounded,
  output logic [1:0]              jumps_left
);

  localparam int unsigned VEL_EXT_W = VEL_W + 1;

  localparam logic signed [CMP_W-1:0]     FULL_H     = CMP_W'(2 * HEIGHT);
  localparam logic signed [CMP_W-1:0]     GROUND_CMP = CMP_W'(GROUND_Y);
  localparam logic signed [POS_W-1:0]     PLAT_TOP   = POS_W'(PLATFORM_Y - 2 * HEIGHT);
  localparam logic signed [POS_W-1:0]     GROUND_TOP = POS_W'(GROUND_Y - 2 * HEIGHT);
  localparam logic signed [POS_W-1:0]     SPAWN_TOP  = POS_W'(SPAWN_Y);
  localparam logic signed [VEL_W-1:0]     JUMP_V     = VEL_W'(JUMP_VEL);
  localparam logic signed [VEL_W-1:0]     MAX_V      = VEL_W'(MAX_FALL);
  localparam logic signed [VEL_EXT_W-1:0] GRAV_EXT   = VEL_EXT_W'(GRAVITY);
  localparam logic signed [VEL_EXT_W-1:0] MAX_V_EXT  = VEL_EXT_W'(MAX_FALL);
  localparam logic [1:0]                  JUMPS_FULL = 2'(MAX_JUMPS);
  localparam logic [1:0]                  JUMPS_WALK = 2'(MAX_JUMPS - 1);

  phys_state_e             state_q, state_d;
  logic signed [POS_W-1:0] y_q, y_d;
  logic signed [VEL_W-1:0] vel_q, vel_d;
  logic [1:0]              jumps_q, jumps_d;

  logic                        jump_req;
  logic                        jump_ok;
  logic                        plat_land;
  logic                        floor_land;
  logic signed [CMP_W-1:0]     bottom_next;
  logic signed [VEL_EXT_W-1:0] vel_grav;
  logic signed [VEL_W-1:0]     vel_fall;

  jump_req_latch u_jump_req (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn     (jump_btn),
    .consume (frame_tick),
    .req     (jump_req)
  );

  assign next_y      = y_q + POS_W'(vel_q);
  assign bottom_next = bottom_edge(y_q, vel_q, FULL_H);
  assign vel_grav    = VEL_EXT_W'(vel_q) + GRAV_EXT;
  assign vel_fall    = (vel_grav >= MAX_V_EXT) ? MAX_V : VEL_W'(vel_grav);
  assign jump_ok     = jump_req && (jumps_q != 2'd0);
  assign plat_land   = touching_platform && !vel_q[VEL_W-1];
  assign floor_land  = bottom_next >= GROUND_CMP;

  // Next-state and datapath update, evaluated only on the frame pulse.
  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    vel_d   = vel_q;
    jumps_d = jumps_q;
    if (frame_tick) begin
      if (jump_ok) begin
        state_d = ST_AIRBORNE;
        vel_d   = JUMP_V;
        jumps_d = jumps_q - 2'd1;
      end else begin
        unique case (state_q)
          ST_AIRBORNE: begin
            if (plat_land) begin
              state_d = ST_PLATFORM;
              y_d     = PLAT_TOP;
              vel_d   = '0;
              jumps_d = JUMPS_FULL;
            end else if (floor_land) begin
              state_d = ST_GROUND;
              y_d     = GROUND_TOP;
              vel_d   = '0;
              jumps_d = JUMPS_FULL;
            end else begin
              y_d   = next_y;
              vel_d = vel_fall;
            end
          end
          ST_PLATFORM: begin
            if (!over_platform) begin
              state_d = ST_AIRBORNE;
              vel_d   = '0;
              jumps_d = JUMPS_WALK;
            end
          end
          ST_GROUND: ;
          default: state_d = ST_AIRBORNE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_AIRBORNE;
      y_q     <= SPAWN_TOP;
      vel_q   <= '0;
      jumps_q <= JUMPS_FULL;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      vel_q   <= vel_d;
      jumps_q <= jumps_d;
    end
  end

  assign y_pos      = y_q;
  assign vel_y      = vel_q;
  assign jumps_left = jumps_q;
  assign grounded   = (state_q != ST_AIRBORNE);

endmodule

// File: tb/tb_player_vert_physics.sv
// Scoreboard bench for player_vert_physics: directed frames with hand-computed expectations.
module tb_player_vert_physics;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic frame_tick = 1'b0;
  logic jump_btn = 1'b0;
  logic touching_platform = 1'b0;
  logic over_platform = 1'b1;
  logic signed [10:0] y_pos;
  logic signed [10:0] next_y;
  logic signed [5:0]  vel_y;
  logic               grounded;
  logic [1:0]         jumps_left;

  player_vert_physics #(.HEIGHT(30), .MAX_JUMPS(2)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .frame_tick        (frame_tick),
    .jump_btn          (jump_btn),
    .touching_platform (touching_platform),
    .over_platform     (over_platform),
    .y_pos             (y_pos),
    .next_y            (next_y),
    .vel_y             (vel_y),
    .grounded          (grounded),
    .jumps_left        (jumps_left)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit    chk;
    int    y;
    int    v;
    bit    g;
    int    j;
    string tag;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_pass = 0;
  logic evt = 1'b0;

  // An output event is any cycle in which reset or a frame pulse was applied.
  always @(posedge clk) evt <= !rst_n || frame_tick;

  always @(negedge clk) begin
    if (evt) begin
      if (sb.size() == 0) begin
        n_chk++;
        $display("FAIL sb_underflow: output event with no expected entry at %0t", $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (e.chk) begin
          n_chk++;
          if (int'(y_pos) == e.y && int'(vel_y) == e.v && int'(next_y) == e.y + e.v &&
              grounded == e.g && int'(jumps_left) == e.j)
            n_pass++;
          else
            $display("FAIL %s: got y=%0d vel=%0d next_y=%0d grounded=%0b jumps=%0d, expected y=%0d vel=%0d next_y=%0d grounded=%0b jumps=%0d",
                     e.tag, y_pos, vel_y, next_y, grounded, jumps_left,
                     e.y, e.v, e.y + e.v, e.g, e.j);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input bit chk, input int y, input int v, input bit g, input int j,
                      input string tag);
    exp_t e;
    e.chk = chk; e.y = y; e.v = v; e.g = g; e.j = j; e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic tick(input bit chk, input int y, input int v, input bit g, input int j,
                      input string tag, input bit tp = 1'b0, input bit op = 1'b1);
    touching_platform = tp;
    over_platform     = op;
    frame_tick        = 1'b1;
    push(chk, y, v, g, j, tag);
    cyc();
    frame_tick        = 1'b0;
    touching_platform = 1'b0;
    over_platform     = 1'b1;
  endtask

  task automatic skip(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 0, 0, 1'b0, 0, "skip");
  endtask

  task automatic press();
    jump_btn = 1'b1;
    cyc();
    jump_btn = 1'b0;
    cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset, then free fall from spawn to the floor.
    rst_n = 1'b0;
    push(1, 100, 0, 0, 2, "reset_a"); cyc();
    push(1, 100, 0, 0, 2, "reset_b"); cyc();
    rst_n = 1'b1;
    cyc();
    tick(1, 100, 1, 0, 2, "spawn_t1");
    tick(1, 101, 2, 0, 2, "spawn_t2");
    tick(1, 103, 3, 0, 2, "spawn_t3");
    skip(6);
    tick(1, 145, 10, 0, 2, "fall_t10");
    skip(18);
    tick(1, 335, 10, 0, 2, "fall_sat");
    tick(1, 340, 0, 1, 2, "floor_land");
    tick(1, 340, 0, 1, 2, "ground_hold", 1'b0, 1'b0);

    // Double jump, third press ignored.
    press(); tick(1, 340, -12, 0, 1, "jump1");
    tick(1, 328, -11, 0, 1, "rise1");
    press(); tick(1, 328, -12, 0, 0, "jump2");
    press(); tick(1, 316, -11, 0, 0, "jump3_ignored");
    tick(1, 305, -10, 0, 0, "rise2");

    // Rising through the platform, then landing on it on the way down.
    tick(1, 295, -9, 0, 0, "pass_thru_v10", 1'b1);
    tick(1, 286, -8, 0, 0, "rise_v9");
    tick(1, 278, -7, 0, 0, "rise_v8");
    tick(1, 271, -6, 0, 0, "rise_v7");
    tick(1, 265, -5, 0, 0, "rise_v6");
    tick(1, 260, -4, 0, 0, "rise_v5");
    tick(1, 256, -3, 0, 0, "rise_v4");
    tick(1, 253, -2, 0, 0, "pass_thru_v3", 1'b1);
    tick(1, 251, -1, 0, 0, "rise_v2");
    tick(1, 250, 0, 0, 0, "apex_a");
    tick(1, 250, 1, 0, 0, "apex_b");
    tick(1, 251, 2, 0, 0, "drop_v1");
    tick(1, 253, 3, 0, 0, "drop_v2");
    tick(1, 256, 4, 0, 0, "drop_v3");
    tick(1, 260, 5, 0, 0, "drop_v4");
    tick(1, 155, 0, 1, 2, "plat_land", 1'b1);
    tick(1, 155, 0, 1, 2, "plat_hold_no_stale_req");

    // Walk off the platform and fall to the floor.
    tick(1, 155, 0, 0, 1, "walk_off", 1'b0, 1'b0);
    skip(9);
    tick(1, 200, 10, 0, 1, "walk_fall10");
    skip(12);
    tick(1, 330, 10, 0, 1, "walk_fall23");
    tick(1, 340, 0, 1, 2, "walk_floor");

    // Reset mid-rise with a coincident frame pulse.
    press(); tick(1, 340, -12, 0, 1, "jump_mid");
    tick(1, 328, -11, 0, 1, "mid_v11");
    tick(1, 317, -10, 0, 1, "mid_v10");
    tick(1, 307, -9, 0, 1, "mid_v9");
    tick(1, 298, -8, 0, 1, "mid_v8");
    rst_n = 1'b0; frame_tick = 1'b1;
    push(1, 100, 0, 0, 2, "reset_mid_rise"); cyc();
    rst_n = 1'b1; frame_tick = 1'b0;
    cyc();
    tick(1, 100, 1, 0, 2, "post_reset_t1");
    skip(27);
    tick(1, 335, 10, 0, 2, "post_reset_t29");
    tick(1, 155, 0, 1, 2, "both_land_plat_wins", 1'b1);
    press(); tick(1, 155, -12, 0, 1, "plat_jump");

    cyc(); cyc();
    n_chk++;
    if (sb.size() == 0) n_pass++;
    else $display("FAIL sb_drain: %0d expected entries left, required 0", sb.size());
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
